// File: rtl/bcd_conv_arbiter.sv
// Round-robin front end that shares one start/done binary-to-BCD engine between
// N_REQ requesters, with a WAIT watchdog and an operand range check.
module bcd_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 20,
  parameter int DIG_N   = 6,
  parameter int MAX_VAL = 999999,
  parameter int TIMEOUT = 64,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int TMR_W  = $clog2(TIMEOUT + 1)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    eng_start,
  output logic [DATA_W-1:0]       eng_data,
  input  logic                    eng_done,
  input  logic [DIG_N*4-1:0]      eng_bcd,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DIG_N*4-1:0]      rsp_bcd,
  output logic                    rsp_err
);

  localparam logic [DATA_W-1:0] MAX_W = DATA_W'(MAX_VAL);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_RESP} state_t;

  state_t             state, state_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic [ID_W-1:0]    last_grant, last_grant_nx;
  logic [N_REQ-1:0]   req_ready_nx;
  logic               eng_start_nx;
  logic [DATA_W-1:0]  eng_data_nx;
  logic               rsp_valid_nx;
  logic [ID_W-1:0]    rsp_id_nx;
  logic [DIG_N*4-1:0] rsp_bcd_nx;
  logic               rsp_err_nx;

  logic [DATA_W-1:0]  opnd [N_REQ];
  logic               found;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    scan_id;
  int                 scan_sum;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      opnd[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Scan from the farthest offset down so the nearest requester after last_grant wins.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    scan_id  = '0;
    scan_sum = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_sum = int'(last_grant) + 1 + i;
      if (scan_sum >= N_REQ) scan_sum = scan_sum - N_REQ;
      scan_id = ID_W'(scan_sum);
      if (req_valid[scan_id]) begin
        found    = 1'b1;
        grant_id = scan_id;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    last_grant_nx = last_grant;
    req_ready_nx  = '0;
    eng_start_nx  = 1'b0;
    eng_data_nx   = eng_data;
    rsp_valid_nx  = 1'b0;
    rsp_id_nx     = rsp_id;
    rsp_bcd_nx    = rsp_bcd;
    rsp_err_nx    = rsp_err;
    case (state)
      ST_IDLE: begin
        if (found) begin
          req_ready_nx[grant_id] = 1'b1;
          rsp_id_nx              = grant_id;
          eng_data_nx            = opnd[grant_id];
          if (opnd[grant_id] <= MAX_W) begin
            eng_start_nx = 1'b1;
            state_nx     = ST_START;
          end else begin
            rsp_valid_nx = 1'b1;
            rsp_err_nx   = 1'b1;
            rsp_bcd_nx   = '0;
            state_nx     = ST_RESP;
          end
        end
      end
      ST_START: begin
        timer_nx = '0;
        state_nx = ST_WAIT;
      end
      // A done arriving on the watchdog's last cycle still counts as success.
      ST_WAIT: begin
        if (eng_done) begin
          rsp_bcd_nx   = eng_bcd;
          rsp_err_nx   = 1'b0;
          rsp_valid_nx = 1'b1;
          state_nx     = ST_RESP;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          rsp_bcd_nx   = '0;
          rsp_err_nx   = 1'b1;
          rsp_valid_nx = 1'b1;
          state_nx     = ST_RESP;
        end else begin
          timer_nx = timer + TMR_W'(1);
        end
      end
      ST_RESP: begin
        last_grant_nx = rsp_id;
        state_nx      = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      timer      <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      req_ready  <= '0;
      eng_start  <= 1'b0;
      eng_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_bcd    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      last_grant <= last_grant_nx;
      req_ready  <= req_ready_nx;
      eng_start  <= eng_start_nx;
      eng_data   <= eng_data_nx;
      rsp_valid  <= rsp_valid_nx;
      rsp_id     <= rsp_id_nx;
      rsp_bcd    <= rsp_bcd_nx;
      rsp_err    <= rsp_err_nx;
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed plus randomized bench for bcd_conv_arbiter; a behavioural engine model
// and an arithmetic reference predict grant order, BCD results, errors and latency.
module tb_bcd_conv_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 20;
  localparam int DIG_N   = 6;
  localparam int MAX_VAL = 999999;
  localparam int TIMEOUT = 64;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    eng_start;
  logic [DATA_W-1:0]       eng_data;
  logic                    eng_done = 1'b0;
  logic [DIG_N*4-1:0]      eng_bcd = '0;
  logic                    rsp_valid;
  logic [1:0]              rsp_id;
  logic [DIG_N*4-1:0]      rsp_bcd;
  logic                    rsp_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc, rsp_cyc, ready_cyc;
  int start_count = 0;
  int grant_q[$];
  logic seen_rsp = 1'b0;
  logic [1:0] cap_id;
  logic [23:0] cap_bcd;
  logic cap_err;
  logic [19:0] cap_eng_data;
  logic [3:0] sticky = 4'b0;
  int eng_lat = 1;
  int model_last = N_REQ - 1;
  int eng_lat_q;
  logic [19:0] eng_opnd;

  bcd_conv_arbiter dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .eng_start (eng_start),
    .eng_data  (eng_data),
    .eng_done  (eng_done),
    .eng_bcd   (eng_bcd),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_bcd   (rsp_bcd),
    .rsp_err   (rsp_err)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  function automatic logic [23:0] toBcd(int unsigned v);
    logic [23:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int d = 0; d < DIG_N; d++) begin
      r[d*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int nextGrant(int last, logic [3:0] mask);
    int id;
    for (int off = 1; off <= N_REQ; off++) begin
      id = (last + off) % N_REQ;
      if (mask[id]) return id;
    end
    return -1;
  endfunction

  // Engine model: answers lat cycles after the start pulse (lat 0 = never answers).
  always begin
    @(posedge sys_clk);
    #1;
    if (eng_start === 1'b1) begin
      eng_lat_q = eng_lat;
      eng_opnd  = eng_data;
      if (eng_lat_q > 0) begin
        repeat (eng_lat_q) @(posedge sys_clk);
        #1;
        eng_done = 1'b1;
        eng_bcd  = toBcd(32'(eng_opnd));
        @(posedge sys_clk);
        #1;
        eng_done = 1'b0;
        eng_bcd  = 24'($urandom);
      end
    end
  end

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    if (eng_start === 1'b1) begin
      start_cyc    = cyc;
      cap_eng_data = eng_data;
      start_count++;
    end
    if (req_ready !== '0) begin
      checkOutput("ready_onehot", 64'($countones(req_ready)), 64'd1);
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) grant_q.push_back(i);
      ready_cyc = cyc;
      req_valid = req_valid & ~(req_ready & ~sticky);
    end
    if (rsp_valid === 1'b1) begin
      seen_rsp = 1'b1;
      rsp_cyc  = cyc;
      cap_id   = rsp_id;
      cap_bcd  = rsp_bcd;
      cap_err  = rsp_err;
    end
  endtask

  task automatic applyStimulus(logic [3:0] mask, logic [19:0] d0, logic [19:0] d1,
                               logic [19:0] d2, logic [19:0] d3);
    if (mask[0]) req_data[0*DATA_W +: DATA_W] = d0;
    if (mask[1]) req_data[1*DATA_W +: DATA_W] = d1;
    if (mask[2]) req_data[2*DATA_W +: DATA_W] = d2;
    if (mask[3]) req_data[3*DATA_W +: DATA_W] = d3;
    req_valid = req_valid | mask;
  endtask

  task automatic checkIdleOutputs(string tag);
    checkOutput({tag, "_ready"}, 64'(req_ready), 64'd0);
    checkOutput({tag, "_start"}, 64'(eng_start), 64'd0);
    checkOutput({tag, "_edata"}, 64'(eng_data), 64'd0);
    checkOutput({tag, "_rvalid"}, 64'(rsp_valid), 64'd0);
    checkOutput({tag, "_rid"}, 64'(rsp_id), 64'd0);
    checkOutput({tag, "_rbcd"}, 64'(rsp_bcd), 64'd0);
    checkOutput({tag, "_rerr"}, 64'(rsp_err), 64'd0);
  endtask

  task automatic doReset(string tag);
    sys_rst_n = 1'b0;
    req_valid = '0;
    sticky    = '0;
    tick();
    tick();
    checkIdleOutputs(tag);
    sys_rst_n = 1'b1;
    tick();
    grant_q.delete();
    model_last = N_REQ - 1;
  endtask

  // Wait for one response and check it against the reference rules.
  task automatic serveExpect(string tag, int exp_id, logic [19:0] data, int lat);
    int n, s0, g, k;
    logic [23:0] eb;
    logic ee;
    eng_lat  = lat;
    seen_rsp = 1'b0;
    s0       = start_count;
    n        = 0;
    while (!seen_rsp && n < 300) begin
      tick();
      n++;
    end
    checkOutput({tag, "_rsp_seen"}, 64'(seen_rsp), 64'd1);
    if (seen_rsp) begin
      g = (grant_q.size() > 0) ? grant_q.pop_front() : -1;
      checkOutput({tag, "_grant"}, 64'(g), 64'(exp_id));
      checkOutput({tag, "_grants_left"}, 64'(grant_q.size()), 64'd0);
      checkOutput({tag, "_id"}, 64'(cap_id), 64'(exp_id));
      if (32'(data) > MAX_VAL) begin
        ee = 1'b1;
        eb = '0;
        checkOutput({tag, "_no_start"}, 64'(start_count - s0), 64'd0);
        checkOutput({tag, "_range_lat"}, 64'(rsp_cyc - ready_cyc), 64'd0);
      end else begin
        ee = (lat == 0 || lat > TIMEOUT);
        k  = ee ? TIMEOUT : lat;
        eb = ee ? 24'd0 : toBcd(32'(data));
        checkOutput({tag, "_one_start"}, 64'(start_count - s0), 64'd1);
        checkOutput({tag, "_start_with_ready"}, 64'(start_cyc - ready_cyc), 64'd0);
        checkOutput({tag, "_edata"}, 64'(cap_eng_data), 64'(data));
        checkOutput({tag, "_edata_hold"}, 64'(eng_data), 64'(data));
        checkOutput({tag, "_latency"}, 64'(rsp_cyc - start_cyc), 64'(1 + k));
      end
      checkOutput({tag, "_bcd"}, 64'(cap_bcd), 64'(eb));
      checkOutput({tag, "_err"}, 64'(cap_err), 64'(ee));
      tick();
      checkOutput({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
    end
    model_last = exp_id;
  endtask

  initial begin
    int n, s0, s1, id, lat;
    logic [3:0] mask, pending;
    logic [19:0] rd [N_REQ];

    sys_rst_n = 1'b0;
    req_valid = '0;
    req_data  = '0;
    doReset("reset");

    // Single request, 44-cycle engine.
    applyStimulus(4'b0001, 20'd123456, 20'd0, 20'd0, 20'd0);
    serveExpect("t1", 0, 20'd123456, 44);

    // All four at once from a fresh reset: plain index order.
    doReset("reset2");
    applyStimulus(4'hF, 20'd1, 20'd22, 20'd333, 20'd4444);
    serveExpect("t2_0", 0, 20'd1, 5);
    serveExpect("t2_1", 1, 20'd22, 1);
    serveExpect("t2_2", 2, 20'd333, 2);
    serveExpect("t2_3", 3, 20'd4444, 10);

    // Two requesters held high alternate.
    sticky = 4'b0101;
    applyStimulus(4'b0101, 20'd777, 20'd0, 20'd888, 20'd0);
    serveExpect("t3_a", 0, 20'd777, 3);
    serveExpect("t3_b", 2, 20'd888, 4);
    serveExpect("t3_c", 0, 20'd777, 2);
    serveExpect("t3_d", 2, 20'd888, 6);
    sticky    = 4'b0;
    req_valid = '0;

    // Watchdog: hung engine, done on the last WAIT cycle, done one cycle too late.
    applyStimulus(4'b1000, 20'd0, 20'd0, 20'd0, 20'd4321);
    serveExpect("t4_hang", 3, 20'd4321, 0);
    applyStimulus(4'b0010, 20'd0, 20'd65, 20'd0, 20'd0);
    serveExpect("t4_edge", 1, 20'd65, 64);
    applyStimulus(4'b0100, 20'd0, 20'd0, 20'd98765, 20'd0);
    serveExpect("t4_late", 2, 20'd98765, 65);
    applyStimulus(4'b0001, 20'd31, 20'd0, 20'd0, 20'd0);
    serveExpect("t4_after", 0, 20'd31, 7);

    // Range check on both sides of the limit.
    applyStimulus(4'b0010, 20'd0, 20'd1000000, 20'd0, 20'd0);
    serveExpect("t5_over", 1, 20'd1000000, 5);
    applyStimulus(4'b0100, 20'd0, 20'd0, 20'hFFFFF, 20'd0);
    serveExpect("t5_max", 2, 20'hFFFFF, 5);
    applyStimulus(4'b0001, 20'd999999, 20'd0, 20'd0, 20'd0);
    serveExpect("t5_limit", 0, 20'd999999, 12);

    // Reset during WAIT: nothing comes out, late done ignored, priority restarts at 0.
    applyStimulus(4'b0010, 20'd0, 20'd555, 20'd0, 20'd0);
    eng_lat = 20;
    s0 = start_count;
    n = 0;
    while (start_count == s0 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("t6_started", 64'(start_count - s0), 64'd1);
    repeat (5) tick();
    sys_rst_n = 1'b0;
    #1;
    checkIdleOutputs("t6_rst");
    tick();
    sys_rst_n = 1'b1;
    seen_rsp = 1'b0;
    s1 = start_count;
    repeat (30) tick();
    checkOutput("t6_no_rsp", 64'(seen_rsp), 64'd0);
    checkOutput("t6_no_start", 64'(start_count - s1), 64'd0);
    grant_q.delete();
    model_last = N_REQ - 1;
    applyStimulus(4'b0011, 20'd10, 20'd11, 20'd0, 20'd0);
    serveExpect("t6_a", 0, 20'd10, 3);
    serveExpect("t6_b", 1, 20'd11, 3);

    // Randomized rounds against the reference model.
    for (int r = 0; r < 30; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(0, 7) == 0) rd[i] = 20'($urandom_range(1000000, 1048575));
        else rd[i] = 20'($urandom_range(0, 999999));
      end
      applyStimulus(mask, rd[0], rd[1], rd[2], rd[3]);
      pending = mask;
      while (pending != 0) begin
        id = nextGrant(model_last, pending);
        case ($urandom_range(0, 11))
          0: lat = 0;
          1: lat = 64;
          2: lat = 65;
          default: lat = $urandom_range(1, 30);
        endcase
        serveExpect($sformatf("rnd%0d_%0d", r, id), id, rd[id], lat);
        pending[id] = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
